// File: rtl/pattern_serializer.sv
// pattern_serializer
// Parallel-to-serial bit-stream transmitter. A WIDTH-bit word is accepted
// over a valid/ready handshake and shifted out MSB-first, one bit per clk.
// Optional repeat (loop) mode retransmits the saved word until stop is seen
// at a word boundary. GAP_CYCLES idle cycles may follow every word.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   load_data   word to transmit (bit WIDTH-1 goes out first)
//   load_valid  load_data / repeat_en are valid
//   load_ready  block can accept a word this cycle (combinational)
//   repeat_en   sampled at accept; 1 = retransmit the word continuously
//   stop        level; ends repeat mode at the next word boundary
//   dout        serial data bit
//   dout_valid  dout carries a word bit this cycle
//   bit_idx     index of the bit currently on dout
//   busy        1 whenever the block is not idle
//   done        1-cycle pulse alongside the last bit of every word
module pattern_serializer #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 0,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             dout,
    output logic             dout_valid,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t             state, state_n;
    logic [WIDTH-1:0]   shift_reg, shift_n;
    logic [WIDTH-1:0]   saved, saved_n;
    logic               rep, rep_n;
    logic [7:0]         gap_cnt, gap_n;
    logic [IDX_W-1:0]   idx_n;
    logic               last_bit;
    logic               accept;

    assign last_bit = (state == SHIFT) && (bit_idx == '0);

    // A new word may enter while idle, or during the final bit of a word
    // that will not be followed by a repeat or a gap, so streams can be
    // packed back-to-back with no idle bit between them.
    always_comb begin
        load_ready = 1'b0;
        if (state == IDLE) begin
            load_ready = 1'b1;
        end else if (last_bit && (!rep || stop) && !HAS_GAP) begin
            load_ready = 1'b1;
        end
    end

    assign accept = load_valid & load_ready;

    // Next-state logic. The repeat flag doubles as the GAP exit choice:
    // it is cleared whenever stop ends the loop, so the end of a gap only
    // needs to look at it (and at a stop raised during the gap itself).
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        saved_n = saved;
        rep_n   = rep;
        gap_n   = gap_cnt;
        idx_n   = bit_idx;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                    shift_n = load_data;
                    saved_n = load_data;
                    rep_n   = repeat_en;
                    idx_n   = TOP_IDX;
                end
            end

            SHIFT: begin
                if (bit_idx != '0) begin
                    shift_n = shift_reg << 1;
                    idx_n   = bit_idx - 1'b1;
                end else if (rep && !stop) begin
                    if (HAS_GAP) begin
                        state_n = GAP;
                        gap_n   = 8'd0;
                    end else begin
                        shift_n = saved;
                        idx_n   = TOP_IDX;
                    end
                end else begin
                    rep_n = 1'b0;
                    if (HAS_GAP) begin
                        state_n = GAP;
                        gap_n   = 8'd0;
                    end else if (accept) begin
                        shift_n = load_data;
                        saved_n = load_data;
                        rep_n   = repeat_en;
                        idx_n   = TOP_IDX;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            GAP: begin
                if (stop) begin
                    rep_n = 1'b0;
                end
                if (gap_cnt == GAP_LAST) begin
                    if (rep && !stop) begin
                        state_n = SHIFT;
                        shift_n = saved;
                        idx_n   = TOP_IDX;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so the first bit of
    // an accepted word is already on dout in the cycle after the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            saved      <= '0;
            rep        <= 1'b0;
            gap_cnt    <= 8'd0;
            bit_idx    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            saved      <= saved_n;
            rep        <= rep_n;
            gap_cnt    <= gap_n;
            bit_idx    <= idx_n;
            dout       <= (state_n == SHIFT) & shift_n[WIDTH-1];
            dout_valid <= (state_n == SHIFT);
            busy       <= (state_n != IDLE);
            done       <= (state_n == SHIFT) && (idx_n == '0);
        end
    end

endmodule
